// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: bus widths, the sequencer
// state encoding and a helper that identifies states owning the bus.
package fetch_sequencer_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_FETCH_EXT = 3'd2,
        S_EXEC      = 3'd3,
        S_MEM       = 3'd4,
        S_HALT      = 3'd5
    } seq_state_e;

    function automatic logic is_bus_state(input seq_state_e s);
        return (s == S_FETCH) || (s == S_FETCH_EXT) || (s == S_MEM);
    endfunction

endpackage

// File: rtl/fetch_sequencer_bus_wait_timer.sv
// Counts cycles a bus request has waited for bus_ready and flags expiry
// when the limit is reached without ready. BUS_TIMEOUT=0 never expires.
module fetch_sequencer_bus_wait_timer #(
    parameter int BUS_TIMEOUT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_active,
    input  logic i_ready,
    output logic o_expire
);

    localparam int CNT_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((BUS_TIMEOUT > 0) ? (BUS_TIMEOUT - 1) : 0);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_limit;

    assign w_at_limit = (BUS_TIMEOUT > 0) && (r_cnt == LIMIT);
    // ready in the limit cycle completes the access, so it suppresses expiry
    assign o_expire   = w_at_limit && i_active && !i_ready;

    // Wait counter: cleared whenever no request is pending or one completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!i_active || i_ready || w_at_limit) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequential front end: fetches opcode and optional extension byte, presents
// them to the decoder, performs the data access and commits the next PC.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000,
    parameter int                BUS_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] ext_byte,
    output logic              instr_valid,
    input  logic              need_ext,
    input  logic              is_mem,
    input  logic              is_store,
    input  logic [DATA_W-1:0] store_data,
    input  logic [ADDR_W-1:0] calc_addr,
    input  logic [ADDR_W-1:0] calc_pcout,
    input  logic              halt_req,
    output logic [DATA_W-1:0] load_data,
    output logic              load_valid,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    input  logic              bus_ready,
    output logic              halted,
    output logic              bus_err
);

    seq_state_e        r_state;
    seq_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_instr;
    logic [DATA_W-1:0] r_ext;
    logic [DATA_W-1:0] r_load_data;
    logic              r_load_valid;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_store;
    logic              r_halt;
    logic              r_bus_err;
    logic [ADDR_W-1:0] w_pc_inc;
    logic              w_expire;

    // single incrementer serves the extension address and both pc+1 commits
    assign w_pc_inc = r_pc + 16'd1;

    fetch_sequencer_bus_wait_timer #(
        .BUS_TIMEOUT(BUS_TIMEOUT)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .i_active(is_bus_state(r_state)),
        .i_ready (bus_ready),
        .o_expire(w_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state selection.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (w_expire)       w_state_nxt = S_HALT;
                else if (bus_ready) w_state_nxt = S_DECODE;
                else                w_state_nxt = S_FETCH;
            end
            S_DECODE: begin
                if (need_ext) w_state_nxt = S_FETCH_EXT;
                else          w_state_nxt = S_EXEC;
            end
            S_FETCH_EXT: begin
                if (w_expire)       w_state_nxt = S_HALT;
                else if (bus_ready) w_state_nxt = S_EXEC;
                else                w_state_nxt = S_FETCH_EXT;
            end
            S_EXEC: begin
                if (is_mem)        w_state_nxt = S_MEM;
                else if (halt_req) w_state_nxt = S_HALT;
                else               w_state_nxt = S_FETCH;
            end
            S_MEM: begin
                if (w_expire)       w_state_nxt = S_HALT;
                else if (bus_ready) w_state_nxt = r_halt ? S_HALT : S_FETCH;
                else                w_state_nxt = S_MEM;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // Bus request decode; address and write data come straight from registers.
    always_comb begin
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = r_pc;
        bus_wdata = 8'h00;
        case (r_state)
            S_FETCH: bus_rd = 1'b1;
            S_FETCH_EXT: begin
                bus_rd   = 1'b1;
                bus_addr = w_pc_inc;
            end
            S_MEM: begin
                bus_addr = r_mem_addr;
                if (r_is_store) begin
                    bus_wr    = 1'b1;
                    bus_wdata = r_wdata;
                end else begin
                    bus_rd = 1'b1;
                end
            end
            default: bus_rd = 1'b0;
        endcase
    end

    // Datapath: fetched bytes, latched access, PC commit and sticky fault.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc         <= RESET_PC;
            r_instr      <= 8'h00;
            r_ext        <= 8'h00;
            r_load_data  <= 8'h00;
            r_load_valid <= 1'b0;
            r_mem_addr   <= 16'h0000;
            r_wdata      <= 8'h00;
            r_is_store   <= 1'b0;
            r_halt       <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_load_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (bus_ready) begin
                        r_instr <= bus_rdata;
                        r_ext   <= 8'h00;
                    end
                end
                S_FETCH_EXT: begin
                    if (bus_ready) begin
                        r_ext <= bus_rdata;
                        r_pc  <= w_pc_inc;
                    end
                end
                S_EXEC: begin
                    r_mem_addr <= calc_addr;
                    r_wdata    <= store_data;
                    r_is_store <= is_store;
                    r_halt     <= halt_req;
                    // memory instructions ignore calc_pcout and commit pc+1 after the access
                    if (!is_mem) begin
                        r_pc <= calc_pcout;
                    end
                end
                S_MEM: begin
                    if (bus_ready) begin
                        r_pc <= w_pc_inc;
                        if (!r_is_store) begin
                            r_load_data  <= bus_rdata;
                            r_load_valid <= 1'b1;
                        end
                    end
                end
                default: r_load_valid <= 1'b0;
            endcase
            if (w_expire) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign pc          = r_pc;
    assign instr       = r_instr;
    assign ext_byte    = r_ext;
    assign instr_valid = (r_state == S_EXEC);
    assign load_data   = r_load_data;
    assign load_valid  = r_load_valid;
    assign halted      = (r_state == S_HALT);
    assign bus_err     = r_bus_err;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequential front end that drives the processor bus on behalf of the combinational address path.
- Holds the architectural PC and fetches instruction bytes, including an optional extension byte for long offsets.
- Presents the fetched bytes to the decoder, then carries out the data access computed by the address calculator and commits the next PC.
- Sits between the address calculator and the single shared 16-bit-address / 8-bit-data memory bus.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- BUS_TIMEOUT, 0, number of cycles a bus request may wait for bus_ready before faulting; 0 disables the timeout.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc  output  16  current PC; drives the address calculator pcin.
- instr  output  8  latched opcode byte.
- ext_byte  output  8  latched extension byte (longoffs).
- instr_valid  output  1  one-cycle pulse in EXEC; instr and ext_byte are stable while it is high.
- need_ext  input  1  decoder flag: the opcode has an extension byte. Sampled in DECODE.
- is_mem  input  1  instruction performs a data access. Sampled in EXEC.
- is_store  input  1  data access is a write. Sampled in EXEC.
- store_data  input  8  write data. Sampled in EXEC.
- calc_addr  input  16  data address from the address calculator. Sampled in EXEC.
- calc_pcout  input  16  next PC from the address calculator. Sampled in EXEC.
- halt_req  input  1  stop after the current instruction. Sampled in EXEC.
- load_data  output  8  read data.
- load_valid  output  1  one-cycle pulse when load_data is updated.
- bus_addr  output  16  bus address.
- bus_rd  output  1  read request.
- bus_wr  output  1  write request.
- bus_wdata  output  8  write data.
- bus_rdata  input  8  read data; valid when bus_ready is high.
- bus_ready  input  1  completes the current request in this cycle.
- halted  output  1  sequencer is in HALT.
- bus_err  output  1  sticky timeout fault.

Behaviour:
- Reset values: pc=RESET_PC; instr=0; ext_byte=0; load_data=0; all strobes, halted and bus_err are 0; state=FETCH.
- Reset overrides everything, including an outstanding bus request: the request drops in the cycle after rst.
- FETCH:
  - Drive bus_rd=1, bus_addr=pc. Hold both until bus_ready.
  - On bus_ready: instr<=bus_rdata; ext_byte<=0; go to DECODE.
- DECODE (1 cycle, decoder settles on instr):
  - need_ext=1: go to FETCH_EXT.
  - need_ext=0: go to EXEC.
- FETCH_EXT:
  - Drive bus_rd=1, bus_addr=pc+1 (16-bit wrap, FFFF->0000).
  - On bus_ready: ext_byte<=bus_rdata; pc<=pc+1; go to EXEC.
- EXEC (1 cycle):
  - instr_valid=1; the address calculator inputs are stable.
  - Latch mem_addr<=calc_addr, wdata<=store_data, nxt<=calc_pcout, and the is_store and halt_req flags.
  - is_mem=1: go to MEM, and the PC commit for this instruction is pc+1 (wrapping), not calc_pcout.
  - is_mem=0: pc<=calc_pcout; go to HALT if halt_req, else FETCH.
- MEM:
  - Drive bus_addr=mem_addr. Drive bus_wr=1 with bus_wdata=wdata for a store, or bus_rd=1 for a load.
  - bus_addr and bus_wdata are held stable until bus_ready.
  - On bus_ready: a load sets load_data<=bus_rdata and pulses load_valid=1 for the next cycle.
  - On bus_ready: pc<=pc+1; go to HALT if the latched halt_req is set, else FETCH.
- HALT: no bus activity; halted=1. Left only by rst.
- Bus rules:
  - bus_rd and bus_wr are never high together.
  - Both are 0 in DECODE, EXEC and HALT; bus_addr=pc in those states.
  - bus_ready outside FETCH, FETCH_EXT and MEM is ignored.
- Timeout, when BUS_TIMEOUT>0:
  - A wait counter clears on entry to each bus state and increments every cycle bus_ready is low.
  - When the counter reaches BUS_TIMEOUT: bus_err<=1 (sticky), request drops, go to HALT, pc unchanged.
  - bus_ready arriving in the same cycle the limit is reached wins: the access completes and there is no fault.
- Latency with zero-wait memory:
  - Short non-memory instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Extension byte: +1 cycle.
  - Memory access: +1 cycle.

Decomposition:
- Shared processor package holds:
  - state encoding enum: FETCH, DECODE, FETCH_EXT, EXEC, MEM, HALT;
  - the bus width constants ADDR_W=16 and DATA_W=8.
- One natural sub-module: bus_wait_timer, holding the wait counter and the limit compare.
- The PC incrementer reuses the existing 16-bit adder.

Test Plan:
- Reset with RESET_PC=16'h0100, zero-wait memory, [0100]=0x12, need_ext=0, is_mem=0, calc_pcout=16'h0101:
  - bus_rd with bus_addr=0100 in cycle 1;
  - instr_valid in cycle 3 with instr=0x12;
  - pc=0101 in cycle 4.
- Extension fetch at pc=16'hFFFF with need_ext=1:
  - second read at bus_addr=0000;
  - ext_byte=[0000];
  - pc=0000 during EXEC.
- Load with calc_addr=16'hFF20, is_store=0, 2 wait cycles, bus_rdata=0xA5:
  - bus_addr=FF20 held for 3 cycles;
  - load_valid pulses once with load_data=0xA5;
  - pc advances by 1.
- Store with calc_addr=16'h1234, store_data=0x5C:
  - bus_wr=1, bus_rd=0, bus_wdata=0x5C, bus_addr stable until ready;
  - no load_valid pulse.
- Timeout with BUS_TIMEOUT=4 and bus_ready held low in FETCH:
  - bus_err=1 and halted=1 after 4 cycles;
  - pc unchanged.
  - Then rst=1 for 1 cycle: bus_err=0, fetch restarts at RESET_PC.
- halt_req=1 in EXEC of a store:
  - the store completes;
  - then halted=1 with no further bus_rd.
